// File: rtl/arb_pkg.sv
// Shared types for the round-robin nibble arbiter.
package arb_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef logic [1:0] chan_idx_t;
  typedef logic [3:0] nibble_t;

endpackage

// File: rtl/mux_4_1.sv
// 4:1 nibble multiplexer driven by a 2-bit select.
module mux_4_1
  import arb_pkg::*;
(
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  always_comb begin
    unique case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: first valid channel after `last`, wrapping modulo 4.
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [3:0] in_valid,
  input  logic [1:0] last,
  output logic [1:0] sel,
  output logic       any_valid
);

  chan_idx_t w_idx;

  // Walk from the farthest candidate to the nearest so the nearest match is written last.
  always_comb begin
    sel   = last;
    w_idx = last;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = last + 2'(k);
      if (in_valid[w_idx]) sel = w_idx;
    end
  end

  assign any_valid = |in_valid;

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// Four-channel round-robin arbiter feeding mux_4_1, with a single-entry valid/ready
// output register.
module rr_arb_mux_4_1
  import arb_pkg::*;
#(
  parameter logic [1:0] LAST_INIT = 2'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_valid,
  output logic [3:0] in_ready,
  input  logic [3:0] in_data0,
  input  logic [3:0] in_data1,
  input  logic [3:0] in_data2,
  input  logic [3:0] in_data3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [1:0] out_src
);

  logic      r_out_valid;
  nibble_t   r_out_data;
  chan_idx_t r_out_src;
  chan_idx_t r_last;

  chan_idx_t w_sel;
  logic      w_any_valid;
  logic      w_load;
  nibble_t   w_mux_data;

  rr_pick_4 u_pick (
    .in_valid  (in_valid),
    .last      (r_last),
    .sel       (w_sel),
    .any_valid (w_any_valid)
  );

  mux_4_1 u_mux (
    .d0  (in_data0),
    .d1  (in_data1),
    .d2  (in_data2),
    .d3  (in_data3),
    .sel (w_sel),
    .y   (w_mux_data)
  );

  assign w_load = w_any_valid && (!r_out_valid || out_ready);

  // Gated by rst_n so no channel sees an accept while the reset edge discards it.
  assign in_ready = (w_load && rst_n) ? (4'b0001 << w_sel) : 4'b0000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 4'h0;
      r_out_src   <= 2'd0;
      r_last      <= LAST_INIT;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_src   <= w_sel;
      r_last      <= w_sel;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule
